// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request-holding front end between the pipeline memory stage
// and mem_system. It captures one aligned load or store, holds the request
// stable until mem_system reports Done, stalls the pipeline meanwhile,
// returns load data with a one-cycle valid pulse and keeps saturating
// hit/miss statistics. ERR is absorbing and left only through rst.
//
// Optional feature: define MEM_REQ_TIMEOUT_EN to add an 8-bit wait counter
// that forces ERR when mem_done has not arrived after TIMEOUT ISSUE cycles.
// Without it, ISSUE waits indefinitely.
module mem_req_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_wdata,
  output logic             pipe_stall,
  output logic [15:0]      rdata,
  output logic             rdata_valid,
  output logic             err,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_data_in,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [15:0]      mem_data_out,
  input  logic             mem_done,
  input  logic             mem_cache_hit,
  input  logic             mem_err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_ERR
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The wait counter is 8 bits wide, so the limit has to fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_req_ctrl: TIMEOUT must be in 1..255");
  end

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             is_wr_q, is_wr_d;
  logic             first_q, first_d;
  logic             first_hit_q, first_hit_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             timed_out;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] wait_q, wait_d;

  // Wait counter: zero outside ISSUE, so it starts from 0 on every entry.
  always_comb begin
    wait_d = (state_q == S_ISSUE) ? wait_q + 8'd1 : 8'd0;
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= 8'd0;
    else     wait_q <= wait_d;
  end

  assign timed_out = (state_q == S_ISSUE) && (wait_q == WAIT_LIMIT);
`else
  assign timed_out = 1'b0;
`endif

  // Next-state, request capture, statistics and combinational outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    is_wr_d     = is_wr_q;
    first_d     = first_q;
    first_hit_d = first_hit_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    pipe_stall  = 1'b0;
    rdata_valid = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          pipe_stall = 1'b1;
          if ((req_rd && req_wr) || req_addr[0]) begin
            // Ambiguous or misaligned request: nothing goes to mem_system.
            state_d = S_ERR;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            is_wr_d = req_wr;
            first_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        pipe_stall = 1'b1;
        mem_rd     = ~is_wr_q;
        mem_wr     = is_wr_q;
        first_d    = 1'b0;
        // Only the first tag compare decides hit vs miss for the statistics.
        if (first_q) first_hit_d = mem_cache_hit;
        if (mem_err) begin
          state_d = S_ERR;
        end else if (mem_done) begin
          if (!is_wr_q) rdata_d = mem_data_out;
          state_d = S_RESP;
        end else if (timed_out) begin
          state_d = S_ERR;
        end
      end

      S_RESP: begin
        // Rd/Wr drop here so mem_system returns to idle without a new request.
        rdata_valid = ~is_wr_q;
        if (first_hit_q) begin
          if (hit_q != CNT_MAX) hit_d = hit_q + 1'b1;
        end else begin
          if (miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
        end
        state_d = S_IDLE;
      end

      S_ERR: begin
        pipe_stall = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      is_wr_q     <= 1'b0;
      first_q     <= 1'b0;
      first_hit_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      is_wr_q     <= is_wr_d;
      first_q     <= first_d;
      first_hit_q <= first_hit_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign err         = (state_q == S_ERR);
  assign rdata       = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;

endmodule
